bram_access_arbiter: RTL and testbench

Shares the single write port (addra/dina/wea) and single read port (addrb/doutb) of the game's 32-bit block RAM between two requesters, master 0 (CPU bus bridge) and master 1 (game/video logic). It also runs a post-reset clear sequence that zero-fills the whole RAM before any requester is served. The block sits directly between the requesters and the RAM instance. It assumes the RAM's 1-cycle registered read and byte write enables.

---
 rtl/bram_access_arbiter_if.sv | 19 +
 rtl/bram_access_arbiter.sv | 153 +++++++++++++++
 tb/tb_bram_access_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_access_arbiter_if.sv
// Requester-side port bundle for bram_access_arbiter: request fields in,
// grant / read-return fields out.
interface bram_access_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WE_W   = 4;

  logic                  req;
  logic [WE_W-1:0]       we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_access_arbiter.sv
// Shares the write port (a) and read port (b) of a 32-bit block RAM between two
// requesters, after an optional post-reset zero-fill of the whole RAM.
module bram_access_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clka,
  input  logic                  rst_n,
  bram_access_arbiter_if.slave  m0,
  bram_access_arbiter_if.slave  m1,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb,
  output logic                  busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WE_W   = 4;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q,   clr_cnt_d;
  logic                  rr_ptr_q,    rr_ptr_d;
  logic [ADDR_WIDTH-1:0] addrb_q,     addrb_d;
  logic                  m0_rvalid_q, m0_rvalid_d;
  logic                  m1_rvalid_q, m1_rvalid_d;

  logic m0_rd, m0_wr, m1_rd, m1_wr;
  logic g0, g1;

  // Request decode: a zero byte-enable mask means read.
  always_comb begin
    m0_wr = m0.req && (m0.we != WE_W'(0));
    m0_rd = m0.req && (m0.we == WE_W'(0));
    m1_wr = m1.req && (m1.we != WE_W'(0));
    m1_rd = m1.req && (m1.we == WE_W'(0));
  end

  // Next state, grants and RAM port drive.
  // rr_ptr_q holds the last same-type conflict winner (1 = m1), so the
  // reset value hands the first conflict to m0.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    addrb_d     = addrb_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    g0          = 1'b0;
    g1          = 1'b0;
    ram_addra   = '0;
    ram_dina    = '0;
    ram_wea     = '0;

    case (state_q)
      ST_CLEAR: begin
        ram_addra = clr_cnt_q;
        ram_dina  = DATA_W'(0);
        ram_wea   = {WE_W{1'b1}};
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (m0.req && m1.req) begin
          if (m0_wr != m1_wr) begin
            g0 = 1'b1;
            g1 = 1'b1;
          end else begin
            g0       = rr_ptr_q;
            g1       = !rr_ptr_q;
            rr_ptr_d = !rr_ptr_q;
          end
        end else begin
          g0 = m0.req;
          g1 = m1.req;
        end

        if (g0 && m0_wr) begin
          ram_addra = m0.addr;
          ram_dina  = m0.wdata;
          ram_wea   = m0.we;
        end else if (g1 && m1_wr) begin
          ram_addra = m1.addr;
          ram_dina  = m1.wdata;
          ram_wea   = m1.we;
        end

        if (g0 && m0_rd) begin
          addrb_d     = m0.addr;
          m0_rvalid_d = 1'b1;
        end else if (g1 && m1_rd) begin
          addrb_d     = m1.addr;
          m1_rvalid_d = 1'b1;
        end
      end

      default: state_d = RESET_STATE;
    endcase

    // Nothing is issued to the RAM or granted while reset is held.
    if (!rst_n) begin
      g0          = 1'b0;
      g1          = 1'b0;
      ram_wea     = '0;
      m0_rvalid_d = 1'b0;
      m1_rvalid_d = 1'b0;
      addrb_d     = addrb_q;
      rr_ptr_d    = rr_ptr_q;
    end
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      rr_ptr_q    <= 1'b1;
      addrb_q     <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      addrb_q     <= addrb_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  // Read port address holds when no read is granted.
  assign ram_addrb = addrb_d;
  assign busy      = (state_q == ST_CLEAR);

  assign m0.gnt    = g0;
  assign m1.gnt    = g1;
  assign m0.rvalid = m0_rvalid_q;
  assign m1.rvalid = m1_rvalid_q;
  assign m0.rdata  = ram_doutb;
  assign m1.rdata  = ram_doutb;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Directed self-checking bench for bram_access_arbiter with a behavioural
// read-before-write, byte-enabled block RAM model.
module tb_bram_access_arbiter;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_dina;
  logic [3:0]    ram_wea;
  logic [AW-1:0] ram_addrb;
  logic [31:0]   ram_doutb;
  logic          busy;
  logic          preload;

  logic [31:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  bram_access_arbiter_if #(.ADDR_WIDTH(AW)) m0_if ();
  bram_access_arbiter_if #(.ADDR_WIDTH(AW)) m1_if ();

  bram_access_arbiter #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clka      (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_wea   (ram_wea),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM model: registered read of the pre-write contents, byte write enables.
  always @(posedge clk) begin
    ram_doutb <= mem[ram_addrb];
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEADBEEF;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
    end
  end

  task automatic drive(input int m, input logic req, input logic [3:0] we,
                       input logic [AW-1:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 4'h0, '0, 32'h0);
    drive(1, 1'b0, 4'h0, '0, 32'h0);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    int busy_cycles;
    int gnt_seen;
    rst_n = 1'b0;
    preload = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    repeat (2) @(posedge clk);
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if ({m0_if.gnt, m1_if.gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {m0_if.gnt, m1_if.gnt}); end
    checks++; if ({m0_if.rvalid, m1_if.rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {m0_if.rvalid, m1_if.rvalid}); end
    checks++; if (ram_wea !== 4'h0) begin errors++; $display("FAIL reset_wea: got %h expected 0", ram_wea); end

    drive(0, 1'b1, 4'hF, AW'(32), 32'h12345678);
    drive(1, 1'b1, 4'hF, AW'(33), 32'h87654321);
    rst_n = 1'b1;
    gnt_seen = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (m0_if.gnt || m1_if.gnt) gnt_seen++;
      step();
    end
    rst_n = 1'b0;
    step();
    checks++; if (ram_wea !== 4'h0) begin errors++; $display("FAIL midclear_reset_wea: got %h expected 0", ram_wea); end
    step();
    checks++; if (dut.clr_cnt_q !== AW'(0)) begin errors++; $display("FAIL midclear_cnt: got %0d expected 0", dut.clr_cnt_q); end
    rst_n = 1'b1;

    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 5000) begin
      if (m0_if.gnt || m1_if.gnt) gnt_seen++;
      busy_cycles++;
      step();
    end
    idle();
    checks++; if (busy_cycles !== 4096) begin errors++; $display("FAIL clear_duration: got %0d expected 4096", busy_cycles); end
    checks++; if (gnt_seen !== 0) begin errors++; $display("FAIL clear_no_gnt: got %0d grants expected 0", gnt_seen); end
  endtask

  task automatic test_clear_reads();
    logic [AW-1:0] addrs [3];
    addrs[0] = AW'(0); addrs[1] = AW'(2047); addrs[2] = AW'(4095);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 4'h0, addrs[i], 32'h0);
      #1;
      checks++; if (m0_if.gnt !== 1'b1) begin errors++; $display("FAIL clear_read_gnt[%0d]: got %b expected 1", addrs[i], m0_if.gnt); end
      step();
      idle();
      checks++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h0) begin
        errors++; $display("FAIL clear_read[%0d]: got rvalid=%b data=%h expected 1/00000000", addrs[i], m0_if.rvalid, m0_if.rdata);
      end
    end
    step();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 4'b0101, AW'(5), 32'h11223344);
    #1;
    checks++; if (m0_if.gnt !== 1'b1 || ram_wea !== 4'b0101 || ram_addra !== AW'(5)) begin
      errors++; $display("FAIL wr_issue: got gnt=%b wea=%h addra=%0d expected 1/5/5", m0_if.gnt, ram_wea, ram_addra);
    end
    step();
    drive(0, 1'b1, 4'h0, AW'(5), 32'h0);
    #1;
    checks++; if (m0_if.gnt !== 1'b1 || m0_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_issue: got gnt=%b rvalid=%b expected 1/0", m0_if.gnt, m0_if.rvalid);
    end
    step();
    idle();
    checks++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h00220044) begin
      errors++; $display("FAIL rd_data: got rvalid=%b data=%h expected 1/00220044", m0_if.rvalid, m0_if.rdata);
    end
    checks++; if (m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid: got %b expected 0", m1_if.rvalid); end
    step();
    checks++; if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_single_cycle: got %b expected 0", m0_if.rvalid); end
  endtask

  task automatic test_round_robin();
    logic          exp0;
    logic [AW-1:0] exp_addr;
    drive(0, 1'b1, 4'hF, AW'(10), 32'h0000_000A);
    drive(1, 1'b1, 4'hF, AW'(11), 32'h0000_000B);
    for (int k = 0; k < 4; k++) begin
      exp0     = (k % 2 == 0);
      exp_addr = exp0 ? AW'(10) : AW'(11);
      #1;
      checks++; if (m0_if.gnt !== exp0 || m1_if.gnt !== !exp0 || ram_addra !== exp_addr) begin
        errors++; $display("FAIL rr_cycle%0d: got gnt0=%b gnt1=%b addra=%0d expected %b/%b/%0d", k, m0_if.gnt, m1_if.gnt, ram_addra, exp0, !exp0, exp_addr);
      end
      step();
    end
    idle();
  endtask

  task automatic test_read_write_same();
    drive(0, 1'b1, 4'h0, AW'(7), 32'h0);
    drive(1, 1'b1, 4'hF, AW'(7), 32'hA5A5A5A5);
    #1;
    checks++; if ({m0_if.gnt, m1_if.gnt} !== 2'b11) begin errors++; $display("FAIL rw_both_gnt: got %b expected 11", {m0_if.gnt, m1_if.gnt}); end
    checks++; if (ram_addrb !== AW'(7) || ram_wea !== 4'hF) begin
      errors++; $display("FAIL rw_ports: got addrb=%0d wea=%h expected 7/f", ram_addrb, ram_wea);
    end
    step();
    idle();
    checks++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h0) begin
      errors++; $display("FAIL rw_old_data: got rvalid=%b data=%h expected 1/00000000", m0_if.rvalid, m0_if.rdata);
    end
    step();
    drive(1, 1'b1, 4'h0, AW'(7), 32'h0);
    #1;
    step();
    idle();
    checks++; if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL rw_new_data: got rvalid=%b data=%h expected 1/a5a5a5a5", m1_if.rvalid, m1_if.rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    logic        exp_gnt;
    logic        exp_rv;
    exp_d[0] = 32'h1111_0001; exp_d[1] = 32'h2222_0002; exp_d[2] = 32'h3333_0003;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 4'hF, AW'(i + 1), exp_d[i]);
      step();
    end
    idle();
    step();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1, 1'b1, 4'h0, AW'(k + 1), 32'h0);
      else idle();
      #1;
      exp_gnt = (k < 3);
      exp_rv  = (k >= 1 && k <= 3);
      checks++; if (m1_if.gnt !== exp_gnt || m1_if.rvalid !== exp_rv || m0_if.rvalid !== 1'b0) begin
        errors++; $display("FAIL b2b_ctrl%0d: got gnt=%b rvalid=%b m0_rvalid=%b expected %b/%b/0", k, m1_if.gnt, m1_if.rvalid, m0_if.rvalid, exp_gnt, exp_rv);
      end
      if (exp_rv) begin
        checks++; if (m1_if.rdata !== exp_d[k-1]) begin
          errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, m1_if.rdata, exp_d[k-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_read();
    int cycles;
    drive(0, 1'b1, 4'h0, AW'(5), 32'h0);
    #1;
    checks++; if (m0_if.gnt !== 1'b1) begin errors++; $display("FAIL squash_gnt: got %b expected 1", m0_if.gnt); end
    #1;
    rst_n = 1'b0;
    step();
    idle();
    checks++; if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL squash_rvalid: got %b expected 0", m0_if.rvalid); end
    step();
    rst_n = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 5000) begin
      cycles++;
      step();
    end
    checks++; if (cycles !== 4096) begin errors++; $display("FAIL reclear_duration: got %0d expected 4096", cycles); end
    drive(0, 1'b1, 4'h0, AW'(5), 32'h0);
    #1;
    step();
    idle();
    checks++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h0) begin
      errors++; $display("FAIL reclear_read: got rvalid=%b data=%h expected 1/00000000", m0_if.rvalid, m0_if.rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_round_robin();
    test_read_write_same();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
